// File: rtl/datamover_cmd_sched.sv
// Round-robin command sequencer for the DataMover S2MM/MM2S command and status channels.
// One transfer is in flight at a time; returned status is matched by tag to the issuing requester.
//
// state    | meaning
// IDLE     | arbitrate between requesters, accept one descriptor
// CMD      | 72-bit command held on the selected channel until tready
// WAIT_STS | waiting for the tagged status or the timeout
// RESP     | one-cycle done pulse to the owning requester
module datamover_cmd_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter bit          BURST_TYPE     = 1'b1
) (
  input  logic        clk_in1,
  input  logic        aresetn,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_dir,
  input  logic [63:0] req_addr,
  input  logic [45:0] req_btt,
  output logic [1:0]  done_valid,
  output logic        done_err,
  output logic [7:0]  done_sts,
  output logic [71:0] s2mm_cmd_tdata,
  output logic        s2mm_cmd_tvalid,
  input  logic        s2mm_cmd_tready,
  output logic [71:0] mm2s_cmd_tdata,
  output logic        mm2s_cmd_tvalid,
  input  logic        mm2s_cmd_tready,
  input  logic [7:0]  s2mm_sts_tdata,
  input  logic        s2mm_sts_tvalid,
  output logic        s2mm_sts_tready,
  input  logic [7:0]  mm2s_sts_tdata,
  input  logic        mm2s_sts_tvalid,
  output logic        mm2s_sts_tready,
  output logic        stale_sts
);

  typedef enum logic [1:0] {IDLE, CMD, WAIT_STS, RESP} state_t;

  state_t      state;
  logic        live;
  logic        last;
  logic [2:0]  seq;
  logic        id;
  logic        dir;
  logic [3:0]  tag;
  logic [31:0] tmo_cnt;

  logic        grant;
  logic        accept;
  logic        dir_g;
  logic [31:0] addr_g;
  logic [22:0] btt_g;
  logic [71:0] cmd_word;
  logic        s2mm_fire;
  logic        mm2s_fire;
  logic        sel_fire;
  logic [7:0]  sel_sts;
  logic        match;
  logic        timeout;
  logic        stale;
  logic        cmd_done;

  always_comb begin
    grant = 1'b0;
    case (req_valid)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

  // live gates acceptance so req_ready stays low until the first edge after reset release
  assign accept    = live && (state == IDLE) && (req_valid != 2'b00);
  assign req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;

  assign dir_g    = grant ? req_dir[1] : req_dir[0];
  assign addr_g   = grant ? req_addr[63:32] : req_addr[31:0];
  assign btt_g    = grant ? req_btt[45:23] : req_btt[22:0];
  assign cmd_word = {4'b0000, seq, grant, addr_g, 1'b0, 1'b1, 6'b000000, BURST_TYPE, btt_g};

  assign s2mm_sts_tready = live;
  assign mm2s_sts_tready = live;
  assign s2mm_fire = s2mm_sts_tvalid & live;
  assign mm2s_fire = mm2s_sts_tvalid & live;
  assign sel_fire  = dir ? mm2s_fire : s2mm_fire;
  assign sel_sts   = dir ? mm2s_sts_tdata : s2mm_sts_tdata;
  assign match     = (state == WAIT_STS) && sel_fire && (sel_sts[3:0] == tag);
  assign timeout   = (state == WAIT_STS) && (TIMEOUT_CYCLES != 0) && (tmo_cnt == TIMEOUT_CYCLES);
  // anything that fired but was not the matching status on the selected channel is dropped
  assign stale     = (s2mm_fire && !(match && !dir)) || (mm2s_fire && !(match && dir));
  assign cmd_done  = dir ? (mm2s_cmd_tvalid && mm2s_cmd_tready) : (s2mm_cmd_tvalid && s2mm_cmd_tready);

  always_ff @(posedge clk_in1 or negedge aresetn) begin
    if (!aresetn) begin
      state           <= IDLE;
      live            <= 1'b0;
      last            <= 1'b1;
      seq             <= 3'd0;
      id              <= 1'b0;
      dir             <= 1'b0;
      tag             <= 4'd0;
      tmo_cnt         <= 32'd0;
      s2mm_cmd_tdata  <= 72'd0;
      s2mm_cmd_tvalid <= 1'b0;
      mm2s_cmd_tdata  <= 72'd0;
      mm2s_cmd_tvalid <= 1'b0;
      done_valid      <= 2'b00;
      done_err        <= 1'b0;
      done_sts        <= 8'h00;
      stale_sts       <= 1'b0;
    end else begin
      live       <= 1'b1;
      done_valid <= 2'b00;
      stale_sts  <= stale;
      case (state)
        IDLE: begin
          if (accept) begin
            last <= grant;
            id   <= grant;
            dir  <= dir_g;
            tag  <= {seq, grant};
            seq  <= seq + 3'd1;
            if (btt_g == 23'd0) begin
              done_valid <= grant ? 2'b10 : 2'b01;
              done_err   <= 1'b1;
              done_sts   <= 8'h00;
              state      <= RESP;
            end else begin
              if (dir_g) begin
                mm2s_cmd_tdata  <= cmd_word;
                mm2s_cmd_tvalid <= 1'b1;
              end else begin
                s2mm_cmd_tdata  <= cmd_word;
                s2mm_cmd_tvalid <= 1'b1;
              end
              state <= CMD;
            end
          end
        end
        CMD: begin
          if (cmd_done) begin
            s2mm_cmd_tvalid <= 1'b0;
            mm2s_cmd_tvalid <= 1'b0;
            tmo_cnt         <= 32'd0;
            state           <= WAIT_STS;
          end
        end
        WAIT_STS: begin
          if (match) begin
            done_valid <= id ? 2'b10 : 2'b01;
            done_err   <= ~sel_sts[7] | sel_sts[6] | sel_sts[5] | sel_sts[4];
            done_sts   <= sel_sts;
            state      <= RESP;
          end else if (timeout) begin
            done_valid <= id ? 2'b10 : 2'b01;
            done_err   <= 1'b1;
            done_sts   <= 8'h00;
            state      <= RESP;
          end else if (TIMEOUT_CYCLES != 0) begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_datamover_cmd_sched.sv
// Directed bench for datamover_cmd_sched: table of single transfers, timeout,
// mid-transfer reset and round-robin sequences, all with hand-computed expectations.
module tb_datamover_cmd_sched;

  logic        clk_in1 = 1'b0;
  logic        aresetn = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [1:0]  req_dir = 2'b00;
  logic [63:0] req_addr = 64'd0;
  logic [45:0] req_btt = 46'd0;
  logic [1:0]  done_valid;
  logic        done_err;
  logic [7:0]  done_sts;
  logic [71:0] s2mm_cmd_tdata, mm2s_cmd_tdata;
  logic        s2mm_cmd_tvalid, mm2s_cmd_tvalid;
  logic        s2mm_cmd_tready = 1'b0, mm2s_cmd_tready = 1'b0;
  logic [7:0]  s2mm_sts_tdata = 8'h00, mm2s_sts_tdata = 8'h00;
  logic        s2mm_sts_tvalid = 1'b0, mm2s_sts_tvalid = 1'b0;
  logic        s2mm_sts_tready, mm2s_sts_tready;
  logic        stale_sts;

  int total = 0;
  int bad = 0;

  always #5 clk_in1 = ~clk_in1;

  datamover_cmd_sched #(.TIMEOUT_CYCLES(16), .BURST_TYPE(1'b1)) dut (
    .clk_in1(clk_in1), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
    .req_addr(req_addr), .req_btt(req_btt),
    .done_valid(done_valid), .done_err(done_err), .done_sts(done_sts),
    .s2mm_cmd_tdata(s2mm_cmd_tdata), .s2mm_cmd_tvalid(s2mm_cmd_tvalid), .s2mm_cmd_tready(s2mm_cmd_tready),
    .mm2s_cmd_tdata(mm2s_cmd_tdata), .mm2s_cmd_tvalid(mm2s_cmd_tvalid), .mm2s_cmd_tready(mm2s_cmd_tready),
    .s2mm_sts_tdata(s2mm_sts_tdata), .s2mm_sts_tvalid(s2mm_sts_tvalid), .s2mm_sts_tready(s2mm_sts_tready),
    .mm2s_sts_tdata(mm2s_sts_tdata), .mm2s_sts_tvalid(mm2s_sts_tvalid), .mm2s_sts_tready(mm2s_sts_tready),
    .stale_sts(stale_sts)
  );

  typedef struct {
    int          gid;
    logic        d;
    logic [31:0] addr;
    logic [22:0] btt;
    logic [7:0]  sts;
    int          noise;   // 0 none, 1 wrong tag on own channel, 2 right tag on other channel
    logic [71:0] exp_td;
    logic        exp_err;
    logic [7:0]  exp_sts;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int gid, input logic d, input logic [31:0] addr, input logic [22:0] btt);
    req_dir[gid] = d;
    req_addr[32*gid +: 32] = addr;
    req_btt[23*gid +: 23] = btt;
    req_valid[gid] = 1'b1;
  endtask

  task automatic drive_sts(input logic ch, input logic [7:0] b);
    if (ch) begin mm2s_sts_tdata = b; mm2s_sts_tvalid = 1'b1; end
    else begin s2mm_sts_tdata = b; s2mm_sts_tvalid = 1'b1; end
  endtask

  task automatic clear_sts();
    s2mm_sts_tvalid = 1'b0;
    mm2s_sts_tvalid = 1'b0;
  endtask

  // Called at a negedge in IDLE with the requester inputs already driven.
  task automatic xfer(input string nm, input int gid, input logic d, input logic z, input logic keep,
                      input logic [71:0] exp_td, input logic [7:0] sts, input int noise,
                      input logic exp_err, input logic [7:0] exp_sts);
    logic [1:0] oh;
    logic [3:0] tg;
    oh = (gid == 1) ? 2'b10 : 2'b01;
    tg = exp_td[67:64];
    #1 chk({nm, ".ready"}, req_ready, oh);
    @(negedge clk_in1);
    if (!keep) req_valid = 2'b00;
    chk({nm, ".ready_low"}, req_ready, 2'b00);
    if (z) begin
      chk({nm, ".z_tvalid"}, {mm2s_cmd_tvalid, s2mm_cmd_tvalid}, 2'b00);
      chk({nm, ".z_done"}, {done_valid, done_err, done_sts}, {oh, 1'b1, 8'h00});
      @(negedge clk_in1);
      chk({nm, ".z_done_end"}, done_valid, 2'b00);
      return;
    end
    chk({nm, ".tvalid"}, {mm2s_cmd_tvalid, s2mm_cmd_tvalid}, d ? 2'b10 : 2'b01);
    chk({nm, ".tdata"}, d ? mm2s_cmd_tdata : s2mm_cmd_tdata, exp_td);
    @(negedge clk_in1);
    chk({nm, ".hold"}, {d ? mm2s_cmd_tvalid : s2mm_cmd_tvalid, d ? mm2s_cmd_tdata : s2mm_cmd_tdata}, {1'b1, exp_td});
    if (d) mm2s_cmd_tready = 1'b1; else s2mm_cmd_tready = 1'b1;
    @(negedge clk_in1);
    s2mm_cmd_tready = 1'b0;
    mm2s_cmd_tready = 1'b0;
    chk({nm, ".tvalid_drop"}, {mm2s_cmd_tvalid, s2mm_cmd_tvalid}, 2'b00);
    if (noise != 0) begin
      if (noise == 1) drive_sts(d, {4'h8, tg ^ 4'h1});
      else drive_sts(~d, {4'h8, tg});
      @(negedge clk_in1);
      clear_sts();
      chk({nm, ".noise"}, {stale_sts, done_valid}, {1'b1, 2'b00});
    end
    drive_sts(d, sts);
    @(negedge clk_in1);
    clear_sts();
    chk({nm, ".done"}, {done_valid, done_err, done_sts, stale_sts}, {oh, exp_err, exp_sts, 1'b0});
    @(negedge clk_in1);
    chk({nm, ".done_end"}, done_valid, 2'b00);
  endtask

  initial begin
    int hit;
    vecs[0] = '{0, 1'b0, 32'hC000_0000, 23'h000200, 8'h80, 0, 72'h00_C0000000_40800200, 1'b0, 8'h80};
    vecs[1] = '{1, 1'b1, 32'h1234_5678, 23'h7FFFFF, 8'hA3, 0, 72'h03_12345678_40FFFFFF, 1'b1, 8'hA3};
    vecs[2] = '{0, 1'b1, 32'h0000_1000, 23'h000001, 8'h84, 1, 72'h04_00001000_40800001, 1'b0, 8'h84};
    vecs[3] = '{1, 1'b0, 32'hFFFF_FFFC, 23'h000010, 8'h07, 0, 72'h07_FFFFFFFC_40800010, 1'b1, 8'h07};
    vecs[4] = '{0, 1'b0, 32'h0000_0040, 23'h000000, 8'h00, 0, 72'h0, 1'b1, 8'h00};
    vecs[5] = '{1, 1'b0, 32'h8000_0000, 23'h000100, 8'hCB, 2, 72'h0B_80000000_40800100, 1'b1, 8'hCB};

    #2;
    chk("rst_outputs", {req_ready, s2mm_cmd_tvalid, mm2s_cmd_tvalid, done_valid, done_err, done_sts, stale_sts},
        {2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0});
    chk("rst_tdata", s2mm_cmd_tdata | mm2s_cmd_tdata, 72'd0);
    chk("rst_sts_ready", {s2mm_sts_tready, mm2s_sts_tready}, 2'b00);
    @(negedge clk_in1);
    aresetn = 1'b1;
    @(negedge clk_in1);
    chk("sts_ready_up", {s2mm_sts_tready, mm2s_sts_tready}, 2'b11);

    for (int i = 0; i < 6; i++) begin
      set_req(vecs[i].gid, vecs[i].d, vecs[i].addr, vecs[i].btt);
      xfer($sformatf("vec%0d", i), vecs[i].gid, vecs[i].d, vecs[i].btt == 23'd0, 1'b0,
           vecs[i].exp_td, vecs[i].sts, vecs[i].noise, vecs[i].exp_err, vecs[i].exp_sts);
    end

    // timeout: seq is now 6, requester 0 -> tag 0xC
    set_req(0, 1'b0, 32'hC000_0000, 23'h000200);
    @(negedge clk_in1);
    req_valid = 2'b00;
    chk("tmo.tdata", {s2mm_cmd_tvalid, s2mm_cmd_tdata}, {1'b1, 72'h0C_C0000000_40800200});
    s2mm_cmd_tready = 1'b1;
    @(negedge clk_in1);
    s2mm_cmd_tready = 1'b0;
    hit = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_in1);
      if (done_valid != 2'b00) begin hit = i; break; end
    end
    chk("tmo.latency", hit, 17);
    chk("tmo.done", {done_valid, done_err, done_sts}, {2'b01, 1'b1, 8'h00});
    @(negedge clk_in1);
    drive_sts(1'b0, 8'h8C);
    @(negedge clk_in1);
    clear_sts();
    chk("tmo.late_stale", {stale_sts, done_valid}, {1'b1, 2'b00});
    @(negedge clk_in1);
    chk("tmo.no_done", done_valid, 2'b00);

    // reset while waiting for status
    set_req(1, 1'b1, 32'h2000_0000, 23'h000080);
    @(negedge clk_in1);
    req_valid = 2'b00;
    chk("rstw.tdata", {mm2s_cmd_tvalid, mm2s_cmd_tdata}, {1'b1, 72'h0F_20000000_40800080});
    mm2s_cmd_tready = 1'b1;
    @(negedge clk_in1);
    mm2s_cmd_tready = 1'b0;
    #2 aresetn = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("rstw.outputs", {req_ready, s2mm_cmd_tvalid, mm2s_cmd_tvalid, done_valid, done_err, done_sts, stale_sts},
        {2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0});
    chk("rstw.tdata0", s2mm_cmd_tdata | mm2s_cmd_tdata, 72'd0);
    chk("rstw.sts_ready", {s2mm_sts_tready, mm2s_sts_tready}, 2'b00);
    req_valid = 2'b00;
    @(negedge clk_in1);
    aresetn = 1'b1;
    @(negedge clk_in1);
    drive_sts(1'b1, 8'h8F);
    @(negedge clk_in1);
    clear_sts();
    chk("rstw.late_stale", {stale_sts, done_valid}, {1'b1, 2'b00});
    @(negedge clk_in1);
    chk("rstw.no_done", done_valid, 2'b00);

    // round robin from fresh state: req0 write, req1 read, both always valid
    set_req(0, 1'b0, 32'h1000_0000, 23'h000040);
    set_req(1, 1'b1, 32'h2000_0000, 23'h000080);
    xfer("rr0", 0, 1'b0, 1'b0, 1'b1, 72'h00_10000000_40800040, 8'h80, 0, 1'b0, 8'h80);
    xfer("rr1", 1, 1'b1, 1'b0, 1'b1, 72'h03_20000000_40800080, 8'h83, 0, 1'b0, 8'h83);
    xfer("rr2", 0, 1'b0, 1'b0, 1'b1, 72'h04_10000000_40800040, 8'h84, 0, 1'b0, 8'h84);
    xfer("rr3", 1, 1'b1, 1'b0, 1'b1, 72'h07_20000000_40800080, 8'h87, 0, 1'b0, 8'h87);
    req_valid = 2'b00;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
